// File: rtl/des_expand_keymix_if.sv
// ---------------------------------------------------------------------------
// des_expand_keymix_if
//   Stream bundle around the DES expansion / key-mix stage.
//   Input side : in_valid/in_ready handshake with in_right, in_left,
//                in_subkey and in_tag.
//   Output side: out_valid/out_ready handshake with out_sbox (eight 6-bit
//                S-box inputs), out_left and out_tag.
//   Modports   : master = producer of inputs / consumer of outputs (bench or
//                upstream logic), slave = the key-mix stage itself.
// ---------------------------------------------------------------------------
interface des_expand_keymix_if #(
    parameter int TAG_W = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_right;
    logic [31:0]       in_left;
    logic [47:0]       in_subkey;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [47:0]       out_sbox;
    logic [31:0]       out_left;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_right, in_left, in_subkey, in_tag, out_ready,
        input  in_ready, out_valid, out_sbox, out_left, out_tag
    );

    modport slave (
        input  in_valid, in_right, in_left, in_subkey, in_tag, out_ready,
        output in_ready, out_valid, out_sbox, out_left, out_tag
    );
endinterface

// File: rtl/des_expand_keymix.sv
// ---------------------------------------------------------------------------
// des_expand_keymix
//   DES round-function front end: out_sbox = E(R) XOR K, registered, with the
//   left half and a round tag carried alongside. A two-entry store (output
//   register plus one skid register) keeps full throughput under downstream
//   backpressure while in_ready stays a pure register output.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   zeroize   (only with DES_KEYMIX_ZEROIZE_EN) flush both entries and clear
//             the output data
//   bus       des_expand_keymix_if.slave: in_* handshake/data, out_* handshake/data
//
// Build option
//   DES_KEYMIX_ZEROIZE_EN  adds the zeroize input and its flush logic.
//
// Occupancy FSM
//   state     | meaning
//   OCC_EMPTY | no entry held, out_valid = 0, in_ready = 1
//   OCC_ONE   | output register holds an entry, skid empty, in_ready = 1
//   OCC_TWO   | output register and skid both hold entries, in_ready = 0
// ---------------------------------------------------------------------------
module des_expand_keymix #(
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DES_KEYMIX_ZEROIZE_EN
    input  logic zeroize,
`endif
    des_expand_keymix_if.slave bus
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t state, state_nxt;

    logic [47:0]      oreg_sbox, skid_sbox;
    logic [31:0]      oreg_left, skid_left;
    logic [TAG_W-1:0] oreg_tag,  skid_tag;

    logic             in_ready_int;
    logic             accept;
    logic             load_oreg;
    logic             oreg_from_skid;
    logic             load_skid;
    logic             clear_all;
    logic [47:0]      mix;

    // DES bit n is in_right[32-n]. Chunk j (0-based, MSB first) takes DES bits
    // 4j .. 4j+5, where bit 0 wraps to 32 and bit 33 wraps to 1; both wraps
    // fall out of taking the vector index modulo 32.
    function automatic logic [47:0] expand(input logic [31:0] r);
        logic [47:0] e;
        int          src;
        int          dst;
        e = '0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 6; k++) begin
                src = (32 - 4*j - k) & 31;
                dst = 47 - 6*j - k;
                e[dst[5:0]] = r[src[4:0]];
            end
        end
        return e;
    endfunction

    assign mix = expand(bus.in_right) ^ bus.in_subkey;

`ifdef DES_KEYMIX_ZEROIZE_EN
    assign in_ready_int = (state != OCC_TWO) && !zeroize;
`else
    assign in_ready_int = (state != OCC_TWO);
`endif

    assign accept = bus.in_valid && in_ready_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_oreg      = 1'b0;
        oreg_from_skid = 1'b0;
        load_skid      = 1'b0;
        clear_all      = 1'b0;

        case (state)
            OCC_EMPTY: begin
                if (accept) begin
                    load_oreg = 1'b1;
                    state_nxt = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        load_oreg = 1'b1;
                    end else begin
                        state_nxt = OCC_EMPTY;
                    end
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = OCC_TWO;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so no new input competes with the skid
                if (bus.out_ready) begin
                    load_oreg      = 1'b1;
                    oreg_from_skid = 1'b1;
                    state_nxt      = OCC_ONE;
                end
            end
            default: begin
                state_nxt = OCC_EMPTY;
            end
        endcase

`ifdef DES_KEYMIX_ZEROIZE_EN
        if (zeroize) begin
            state_nxt      = OCC_EMPTY;
            load_oreg      = 1'b0;
            oreg_from_skid = 1'b0;
            load_skid      = 1'b0;
            clear_all      = 1'b1;
        end
`endif
    end

    // Data registers only move on a load, so the outputs stay quiet while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_sbox <= '0;
            oreg_left <= '0;
            oreg_tag  <= '0;
            skid_sbox <= '0;
            skid_left <= '0;
            skid_tag  <= '0;
        end else if (clear_all) begin
            oreg_sbox <= '0;
            oreg_left <= '0;
            oreg_tag  <= '0;
            skid_sbox <= '0;
            skid_left <= '0;
            skid_tag  <= '0;
        end else begin
            if (load_oreg) begin
                if (oreg_from_skid) begin
                    oreg_sbox <= skid_sbox;
                    oreg_left <= skid_left;
                    oreg_tag  <= skid_tag;
                end else begin
                    oreg_sbox <= mix;
                    oreg_left <= bus.in_left;
                    oreg_tag  <= bus.in_tag;
                end
            end
            if (load_skid) begin
                skid_sbox <= mix;
                skid_left <= bus.in_left;
                skid_tag  <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state != OCC_EMPTY);
    assign bus.out_sbox  = oreg_sbox;
    assign bus.out_left  = oreg_left;
    assign bus.out_tag   = oreg_tag;

endmodule

// File: tb/tb_des_expand_keymix.sv
// ---------------------------------------------------------------------------
// tb_des_expand_keymix
//   Self-checking bench for des_expand_keymix. Expected outputs are pushed to
//   a queue on every accepted input and popped when the stage hands a word
//   downstream. Build with +define+DES_KEYMIX_ZEROIZE_EN to cover zeroize.
// ---------------------------------------------------------------------------
module tb_des_expand_keymix;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [47:0]      sbox;
        logic [31:0]      left;
        logic [TAG_W-1:0] tag;
    } txn_t;

    logic clk;
    logic rst_n;
`ifdef DES_KEYMIX_ZEROIZE_EN
    logic zeroize;
`endif

    des_expand_keymix_if #(.TAG_W(TAG_W)) bus ();

    des_expand_keymix #(.TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef DES_KEYMIX_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .bus     (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    txn_t sb_q[$];

    // E table, DES numbering: entry i gives the R bit feeding E bit i+1.
    int e_tab[48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] model_e(input logic [31:0] r);
        logic [47:0] e;
        for (int i = 0; i < 48; i++) e[47-i] = r[32 - e_tab[i]];
        return e;
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_out++;
            if (sb_q.size() == 0) begin
                chk("sb_empty", 64'(bus.out_tag), 64'hFFFF);
            end else begin
                txn_t e;
                e = sb_q.pop_front();
                chk("out_sbox", 64'(bus.out_sbox), 64'(e.sbox));
                chk("out_left", 64'(bus.out_left), 64'(e.left));
                chk("out_tag",  64'(bus.out_tag),  64'(e.tag));
            end
        end
    end

    task automatic send(input logic [31:0] r, input logic [47:0] k, input logic [31:0] l,
                        input logic [TAG_W-1:0] t, input logic [47:0] exp_sbox);
        bit   accepted;
        txn_t e;
        accepted      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_right  = r;
        bus.in_subkey = k;
        bus.in_left   = l;
        bus.in_tag    = t;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                e.sbox = exp_sbox;
                e.left = l;
                e.tag  = t;
                sb_q.push_back(e);
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept", 64'(accepted), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] t);
        logic [31:0] r;
        logic [47:0] k;
        logic [31:0] l;
        r = $urandom;
        k = {16'($urandom), 32'($urandom)};
        l = $urandom;
        send(r, k, l, t, model_e(r) ^ k);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100; c++) begin
            if (sb_q.size() == 0 && bus.out_valid === 1'b0) break;
            @(posedge clk); #1;
        end
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        bit  done;

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_right  = '0;
        bus.in_left   = '0;
        bus.in_subkey = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
`ifdef DES_KEYMIX_ZEROIZE_EN
        zeroize       = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_sbox",  64'(bus.out_sbox),  64'd0);
        chk("rst_out_left",  64'(bus.out_left),  64'd0);
        chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // all-zero input, one-cycle latency, out_valid for a single cycle
        send(32'h0, 48'h0, 32'h0, 4'h0, 48'h000000000000);
        chk("t1_valid_rise", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        chk("t1_valid_fall", 64'(bus.out_valid), 64'd0);

        // known vectors: mixed, E alone, wrap bits
        send(32'hF0AAF0AA, 48'h1B02EFFC7072, 32'hCC00CCFF, 4'h1, 48'h6117BA866527);
        send(32'hF0AAF0AA, 48'h0,            32'h11223344, 4'h2, 48'h7A15557A1555);
        send(32'h00000001, 48'h0,            32'h0,        4'h3, 48'h800000000002);
        send(32'h80000000, 48'h0,            32'h0,        4'h4, model_e(32'h80000000));
        wait_drain();

        // backpressure: two accepted, third held until out_ready rises
        bus.out_ready = 1'b0;
        send(32'h01234567, 48'h0, 32'hA1, 4'h1, model_e(32'h01234567));
        send(32'h89ABCDEF, 48'h0, 32'hA2, 4'h2, model_e(32'h89ABCDEF));
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        bus.in_valid  = 1'b1;
        bus.in_right  = 32'hDEADBEEF;
        bus.in_subkey = 48'h0;
        bus.in_left   = 32'hA3;
        bus.in_tag    = 4'h3;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_tag",   64'(bus.out_tag),  64'd1);
        chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        n0 = n_out;
        bus.out_ready = 1'b1;
        send(32'hDEADBEEF, 48'h0, 32'hA3, 4'h3, model_e(32'hDEADBEEF));
        @(posedge clk); #1;
        chk("bp_rate", 64'(n_out - n0), 64'd3);
        wait_drain();

        // random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) send_rand(4'(i));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();

        // reset with both entries full
        bus.out_ready = 1'b0;
        send(32'h13572468, 48'h5, 32'hB1, 4'h5, model_e(32'h13572468) ^ 48'h5);
        send(32'h24681357, 48'h6, 32'hB2, 4'h6, model_e(32'h24681357) ^ 48'h6);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_sbox",  64'(bus.out_sbox),  64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 64'(bus.in_ready),  64'd1);
        chk("rst_rel_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        send(32'hCAFEF00D, 48'hABCDEF012345, 32'hB3, 4'h7,
             model_e(32'hCAFEF00D) ^ 48'hABCDEF012345);
        wait_drain();

`ifdef DES_KEYMIX_ZEROIZE_EN
        // zeroize with both entries full and an input presented
        bus.out_ready = 1'b0;
        send(32'h11111111, 48'h1, 32'hC1, 4'h8, model_e(32'h11111111) ^ 48'h1);
        send(32'h22222222, 48'h2, 32'hC2, 4'h9, model_e(32'h22222222) ^ 48'h2);
        bus.in_valid  = 1'b1;
        bus.in_right  = 32'h33333333;
        bus.in_tag    = 4'hA;
        zeroize       = 1'b1;
        #1;
        chk("zz_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        zeroize      = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        chk("zz_valid", 64'(bus.out_valid), 64'd0);
        chk("zz_sbox",  64'(bus.out_sbox),  64'd0);
        chk("zz_left",  64'(bus.out_left),  64'd0);
        chk("zz_tag",   64'(bus.out_tag),   64'd0);
        chk("zz_ready_back", 64'(bus.in_ready), 64'd1);
        n0 = n_out;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("zz_no_leak", 64'(n_out - n0), 64'd0);

        // zeroize with one entry: in_ready must still be forced low
        bus.out_ready = 1'b0;
        send(32'h44444444, 48'h4, 32'hC4, 4'hB, model_e(32'h44444444) ^ 48'h4);
        bus.in_valid = 1'b1;
        zeroize      = 1'b1;
        #1;
        chk("zz1_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        zeroize      = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        chk("zz1_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        send(32'h55555555, 48'h5, 32'hC5, 4'hC, model_e(32'h55555555) ^ 48'h5);
        wait_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
